// File: rtl/logic_op_pkg.sv
// Shared definitions for the registered bitwise-op pipe: operation encoding
// and the values the output stage and accumulator take on reset.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  localparam logic RST_VALID = 1'b0;
  localparam logic RST_ACC_BIT = 1'b0;
  localparam logic RST_Y_BIT = 1'b0;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational WIDTH-bit bitwise operator; NOT and PASS ignore b.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Single-entry elastic stage around logic_op_core with a chaining accumulator;
// flags are reduced from the output register so no in_* path reaches out_*.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic [WIDTH-1:0] acc_q
);

  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] y_q;
  logic             v_q;

  assign in_ready = !v_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the same cycle as an accumulating beat makes that beat see zero.
  assign acc_eff = acc_clr ? '0 : acc_q;
  assign b_eff   = in_acc ? acc_eff : in_b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a  (in_a),
    .b  (b_eff),
    .op (op_e'(in_op)),
    .y  (res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= RST_VALID;
      y_q   <= {WIDTH{RST_Y_BIT}};
      acc_q <= {WIDTH{RST_ACC_BIT}};
    end else begin
      if (accept) begin
        y_q <= res;
        v_q <= 1'b1;
      end else if (out_ready) begin
        v_q <= 1'b0;
      end
      if (accept && in_acc)
        acc_q <= res;
      else if (acc_clr)
        acc_q <= '0;
    end
  end

  assign out_valid = v_q;
  assign out_y     = y_q;
  assign out_zero  = ~|y_q;
  assign out_ones  = &y_q;
  assign out_par   = ^y_q;

endmodule
